byte_word_arbiter: RTL
======================

// Module: byte_word_arbiter
// PURPOSE
//  Shares one 8->32 byte packer (compress_4-style: packs 4 accepted bytes LSB-first, pulses word valid
//  1 cycle after the 4th byte) between NUM_SRC byte sources. Grants one source for a whole word so
//  bytes never interleave. Tags each packed word with its source id. Zero-pads a stalled partial word.
// PARAMETERS
//  NUM_SRC       4    number of byte sources (2..8)
//  WORD_BYTES    4    bytes per packed word; must match the packer
//  STALL_CYCLES  64   idle cycles on a granted source before release (count==0) or pad (count>0)
// PORTS
//  clk_in           in   1              system clock
//  rst_n_in         in   1              asynchronous active-low reset
//  src_valid_in     in   NUM_SRC        per-source byte valid
//  src_data_in      in   NUM_SRC*8      per-source byte, source i at [8i+7:8i]
//  src_ready_out    out  NUM_SRC        per-source ready (combinational from state/grant only)
//  byte_valid_out   out  1              to packer valid_data_in (registered)
//  byte_out         out  8              to packer data_in (registered)
//  tag_valid_out    out  1              pulse aligned with packer word-valid
//  tag_src_out      out  $clog2(NUM_SRC) source id of the completed word
//  tag_padded_out   out  1              word contains pad bytes
//  busy_out         out  1              state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, all outputs 0, last_grant=NUM_SRC-1, counters 0.
//  Packer must be reset by the same reset event; the arbiter never repairs packer byte alignment.
//  States: IDLE, LOCKED, PAD.
//  IDLE: if any src_valid_in, pick first valid at (last_grant+1 .. wrapping) -> grant, LOCKED,
//   byte_cnt=0, stall=0. Arbitration costs 1 cycle; no ready in IDLE.
//  LOCKED: src_ready_out[grant]=1, all others 0. Handshake = valid&ready. On handshake: register
//   byte into byte_out, byte_valid_out=1 next cycle, byte_cnt++, stall=0. No handshake: stall++,
//   byte_valid_out=0 next cycle.
//   Handshake with byte_cnt==WORD_BYTES-1 -> IDLE, last_grant=grant, tag pending (padded=0).
//   stall==STALL_CYCLES-1 without handshake: byte_cnt==0 -> IDLE, last_grant=grant, no tag;
//   byte_cnt>0 -> PAD.
//  PAD: all ready 0; emit byte 0x00 with byte_valid_out=1 each cycle until byte_cnt reaches
//   WORD_BYTES, then IDLE, last_grant=grant, tag pending (padded=1).
//  Tag: tag_valid_out high exactly 1 cycle, 2 cycles after the final handshake/pad cycle (i.e. 1 cycle
//   after final byte_valid_out), same cycle as packer word-valid. tag_src_out/tag_padded_out hold
//   until next tag.
//  Throughput: a source streaming continuously gets 1 byte/cycle; min WORD_BYTES+1 cycles per word.
//  Simultaneous requests: strict round-robin, the just-served source is lowest priority next.
//  A granted source dropping valid mid-word keeps the grant until stall timeout.
//  byte_cnt width $clog2(WORD_BYTES+1); stall width $clog2(STALL_CYCLES); neither wraps.
//  Reset mid-word: everything returns to reset values immediately; partial word is lost, no tag.
// STRUCTURE
//  byte_arb_pkg: typedef enum logic[1:0] {IDLE,LOCKED,PAD} arb_state_t; BYTE_W=8.
//  Sub-module rr_pick #(N): combinational round-robin picker (req vector, last index -> grant
//  index, any). Rest (FSM, counters, output regs, tag pipeline) stays in byte_word_arbiter.
// TESTING (bench instantiates compress_4 behind the arbiter, shared reset)
//  Src0 sends 11,22,33,44 back-to-back -> word 0x44332211, tag_src=0, padded=0, tag on word-valid.
//  Src1 and src3 both valid from reset -> src1 word first, then src3; no byte interleave.
//  All 4 sources continuously valid for 8 words -> grants 0,1,2,3,0,1,2,3.
//  Src2 sends AA,BB then stops -> after STALL_CYCLES: word 0x0000BBAA, tag_src=2, padded=1.
//  Src0 granted, never sends -> release after STALL_CYCLES, no tag, src1 granted next if valid.
//  rst_n_in pulsed low after 2 bytes -> outputs 0 same cycle; next full word packs correctly.

Source files
------------

// File: rtl/byte_arb_pkg.sv
// Shared types and constants for the byte-to-word arbiter.
package byte_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    PAD
  } arb_state_t;

  localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after the last served index.
module rr_pick #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] last,
  output logic [IdxW-1:0] grant,
  output logic            any
);

  logic [N-1:0] rot;
  int unsigned  off;
  int unsigned  sum;

  always_comb begin
    // Rotate so bit 0 is the slot just after the last served source.
    rot   = N'({req, req} >> (32'(last) + 32'd1));
    any   = 1'b0;
    off   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        off = i;
      end
    end
    sum = 32'(last) + 32'd1 + off;
    if (sum >= N) begin
      sum = sum - N;
    end
    grant = IdxW'(sum);
  end

endmodule

// File: rtl/byte_word_arbiter.sv
// Grants one byte source for a whole packed word, feeds the shared packer, zero-pads stalled
// partial words and tags each completed word with its source id.
module byte_word_arbiter
  import byte_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC      = 4,
  parameter  int unsigned WORD_BYTES   = 4,
  parameter  int unsigned STALL_CYCLES = 64,
  localparam int unsigned SrcW         = $clog2(NUM_SRC)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_SRC-1:0]      src_valid_in,
  input  logic [NUM_SRC*8-1:0]    src_data_in,
  output logic [NUM_SRC-1:0]      src_ready_out,
  output logic                    byte_valid_out,
  output logic [7:0]              byte_out,
  output logic                    tag_valid_out,
  output logic [SrcW-1:0]         tag_src_out,
  output logic                    tag_padded_out,
  output logic                    busy_out
);

  localparam int unsigned CntW   = $clog2(WORD_BYTES + 1);
  localparam int unsigned StallW = $clog2(STALL_CYCLES);

  localparam logic [CntW-1:0]   CntLast   = CntW'(WORD_BYTES - 1);
  localparam logic [StallW-1:0] StallLast = StallW'(STALL_CYCLES - 1);
  localparam logic [SrcW-1:0]   SrcLast   = SrcW'(NUM_SRC - 1);

  arb_state_t        state;
  logic [SrcW-1:0]   grant;
  logic [SrcW-1:0]   last_grant;
  logic [CntW-1:0]   byte_cnt;
  logic [StallW-1:0] stall;
  logic              tag_pend;
  logic              tag_pend_pad;

  logic [BYTE_W-1:0] src_byte [NUM_SRC];
  logic [BYTE_W-1:0] cur_byte;
  logic [SrcW-1:0]   pick_idx;
  logic              pick_any;
  logic              hs;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_byte[i] = src_data_in[i*BYTE_W +: BYTE_W];
    end
  end

  assign cur_byte = src_byte[grant];
  assign hs       = (state == LOCKED) && src_valid_in[grant];
  assign busy_out = (state != IDLE);

  always_comb begin
    src_ready_out = '0;
    if (state == LOCKED) begin
      src_ready_out[grant] = 1'b1;
    end
  end

  rr_pick #(
    .N (NUM_SRC)
  ) u_rr_pick (
    .req   (src_valid_in),
    .last  (last_grant),
    .grant (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      grant          <= '0;
      last_grant     <= SrcLast;
      byte_cnt       <= '0;
      stall          <= '0;
      tag_pend       <= 1'b0;
      tag_pend_pad   <= 1'b0;
      byte_valid_out <= 1'b0;
      byte_out       <= '0;
      tag_valid_out  <= 1'b0;
      tag_src_out    <= '0;
      tag_padded_out <= 1'b0;
    end else begin
      byte_valid_out <= 1'b0;
      tag_valid_out  <= tag_pend;
      tag_pend       <= 1'b0;
      // last_grant cannot move in the cycle after completion: IDLE always lasts one cycle.
      if (tag_pend) begin
        tag_src_out    <= last_grant;
        tag_padded_out <= tag_pend_pad;
      end
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant    <= pick_idx;
            state    <= LOCKED;
            byte_cnt <= '0;
            stall    <= '0;
          end
        end
        LOCKED: begin
          if (hs) begin
            byte_out       <= cur_byte;
            byte_valid_out <= 1'b1;
            byte_cnt       <= byte_cnt + 1'b1;
            stall          <= '0;
            if (byte_cnt == CntLast) begin
              state        <= IDLE;
              last_grant   <= grant;
              tag_pend     <= 1'b1;
              tag_pend_pad <= 1'b0;
            end
          end else if (stall == StallLast) begin
            stall <= '0;
            if (byte_cnt == '0) begin
              state      <= IDLE;
              last_grant <= grant;
            end else begin
              state <= PAD;
            end
          end else begin
            stall <= stall + 1'b1;
          end
        end
        PAD: begin
          byte_out       <= '0;
          byte_valid_out <= 1'b1;
          byte_cnt       <= byte_cnt + 1'b1;
          if (byte_cnt == CntLast) begin
            state        <= IDLE;
            last_grant   <= grant;
            tag_pend     <= 1'b1;
            tag_pend_pad <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
